// File: rtl/skid_pkg.sv
// Shared types and constants for the two-entry skid buffer.
package skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic RST_DATA = '0;

endpackage

// File: rtl/skid_reg.sv
// WIDTH-bit data register with synchronous reset and load enable.
module skid_reg
    import skid_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= {WIDTH{RST_DATA}};
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry elastic stage: main_q feeds out_data, skid_q absorbs one word
// when the consumer stalls. in_ready and out_valid decode only the state register.
module skid_buffer
    import skid_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output state_t           dbg_state
);

    // Handshake: a word moves on a rising edge when valid && ready are both
    // high on that side; a producer holds valid and data stable until accepted.
    state_t           state_q;
    state_t           state_d;
    logic             in_xfer;
    logic             out_xfer;
    logic             main_en;
    logic             main_sel_skid;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign dbg_state = state_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        main_en       = 1'b0;
        main_sel_skid = 1'b0;
        skid_en       = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    main_en = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_en = 1'b1;
                end else if (in_xfer) begin
                    state_d = TWO;
                    skid_en = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // The skid word moves up so ordering is preserved.
                if (out_xfer) begin
                    state_d       = ONE;
                    main_en       = 1'b1;
                    main_sel_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign main_d = main_sel_skid ? skid_q : in_data;

    skid_reg #(.WIDTH(WIDTH)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (out_data)
    );

    skid_reg #(.WIDTH(WIDTH)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

endmodule
